regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clear_fsm.sv | 58 +++++
 rtl/regfile_param.sv | 80 ++++++++
 tb/tb_regfile_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file: default sizes and
// the clear-sweep state encoding.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_NRD    = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller: walks ptr from 1 to the last entry, one entry per
// cycle, whenever a clear is requested or reset is applied.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              sweep_start,
    output logic [ADDR_W-1:0] ptr
);

    clear_state_t      state;
    clear_state_t      state_next;
    logic [ADDR_W-1:0] ptr_next;

    // Reset starts a sweep directly, so storage is zeroed without a one-cycle reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= ADDR_W'(1);
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        sweep_start = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next  = CLEAR;
                    ptr_next    = ADDR_W'(1);
                    sweep_start = 1'b1;
                end
            end
            CLEAR: begin
                ptr_next = ptr + 1'b1;
                // Entry 0 is hardwired, so the sweep ends after the all-ones entry.
                if (ptr == '1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == CLEAR);

endmodule

// File: rtl/regfile_param.sv
// Multi-read-port register file with registered reads, write-first bypass,
// a hardwired zero entry and a cycle-by-cycle clear sweep.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NRD    = DEFAULT_NRD
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    input  logic                  writeenable,
    input  logic [ADDR_W-1:0]     writeto,
    input  logic [DATA_W-1:0]     writedat,
    input  logic                  clear_req,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic              sweep_start;
    logic              wr_commit;
    logic              read_block;

    regfile_clear_fsm #(
        .ADDR_W(ADDR_W)
    ) u_clear_fsm (
        .clock      (clock),
        .reset      (reset),
        .clear_req  (clear_req),
        .busy       (busy),
        .sweep_start(sweep_start),
        .ptr        (ptr)
    );

    // A pending clear or reset takes priority over any write in the same cycle.
    assign wr_commit  = writeenable && !busy && !clear_req && !reset && (writeto != '0);
    assign read_block = reset || busy || sweep_start;

    always_ff @(posedge clock) begin
        if (busy) begin
            mem[ptr] <= '0;
        end else if (wr_commit) begin
            mem[writeto] <= writedat;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_read
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_next;
        logic [DATA_W-1:0] rd_q;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        // Reads are forced to zero for the whole time busy is (or is about to be) high.
        always_comb begin
            rd_next = mem[ra];
            if (read_block || (ra == '0)) begin
                rd_next = '0;
            end else if (wr_commit && (writeto == ra)) begin
                rd_next = writedat;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_next;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd_q;
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param at default sizes and at
// NRD=4, ADDR_W=3.
module tb_regfile_param;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        writeenable;
    logic [4:0]  writeto;
    logic [31:0] writedat;
    logic        clear_req;
    logic        busy;

    logic         reset4;
    logic [11:0]  raddr4;
    logic [127:0] rdata4;
    logic         writeenable4;
    logic [2:0]   writeto4;
    logic [31:0]  writedat4;
    logic         clear_req4;
    logic         busy4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_param dut (
        .clock      (clock),
        .reset      (reset),
        .raddr      (raddr),
        .rdata      (rdata),
        .writeenable(writeenable),
        .writeto    (writeto),
        .writedat   (writedat),
        .clear_req  (clear_req),
        .busy       (busy)
    );

    regfile_param #(
        .DATA_W(32),
        .ADDR_W(3),
        .NRD   (4)
    ) dut4 (
        .clock      (clock),
        .reset      (reset4),
        .raddr      (raddr4),
        .rdata      (rdata4),
        .writeenable(writeenable4),
        .writeto    (writeto4),
        .writedat   (writedat4),
        .clear_req  (clear_req4),
        .busy       (busy4)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Drives one cycle of inputs on the default instance; write and clear are pulses.
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic clr, input logic [4:0] ra0, input logic [4:0] ra1);
        writeenable = we;
        writeto     = wa;
        writedat    = wd;
        clear_req   = clr;
        raddr       = {ra1, ra0};
        tick();
        writeenable = 1'b0;
        clear_req   = 1'b0;
    endtask

    task automatic countBusy(input bit use4, output int n);
        n = 0;
        while (((use4 ? busy4 : busy) === 1'b1) && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int n;
        logic [31:0] exp4 [4];

        reset        = 1'b1;
        raddr        = '0;
        writeenable  = 1'b0;
        writeto      = '0;
        writedat     = '0;
        clear_req    = 1'b0;
        reset4       = 1'b1;
        raddr4       = '0;
        writeenable4 = 1'b0;
        writeto4     = '0;
        writedat4    = '0;
        clear_req4   = 1'b0;

        // Reset sweep and an all-zero read-back
        tick();
        reset = 1'b0;
        checkOutput("reset_busy", {31'b0, busy}, 32'd1);
        checkOutput("reset_rdata0", rdata[31:0], 32'd0);
        checkOutput("reset_rdata1", rdata[63:32], 32'd0);
        countBusy(1'b0, n);
        checkOutput("reset_sweep_len", n, 32'd31);
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'(a), 5'(31 - a));
            checkOutput($sformatf("zero_p0_%0d", a), rdata[31:0], 32'd0);
            checkOutput($sformatf("zero_p1_%0d", 31 - a), rdata[63:32], 32'd0);
        end

        // Plain write then read, and the hardwired zero entry
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
        checkOutput("read5", rdata[31:0], 32'hDEADBEEF);
        applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd5);
        checkOutput("write0_bypass", rdata[31:0], 32'd0);
        checkOutput("read5_p1", rdata[63:32], 32'hDEADBEEF);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        checkOutput("read0", rdata[31:0], 32'd0);

        // Write-first bypass on both ports
        applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd7, 5'd7);
        checkOutput("bypass_p0", rdata[31:0], 32'hA5A5A5A5);
        checkOutput("bypass_p1", rdata[63:32], 32'hA5A5A5A5);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd5);
        checkOutput("after_bypass_p0", rdata[31:0], 32'hA5A5A5A5);
        checkOutput("after_bypass_p1", rdata[63:32], 32'hDEADBEEF);

        // Fill, clear sweep with a blocked write during busy
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 5'd0);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd31, 5'd3);
        checkOutput("fill31", rdata[31:0], 32'd31);
        checkOutput("fill3", rdata[63:32], 32'd3);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 5'd3);
        checkOutput("clear_busy", {31'b0, busy}, 32'd1);
        checkOutput("clear_edge_rd", rdata[31:0], 32'd0);
        applyStimulus(1'b1, 5'd3, 32'hFF, 1'b0, 5'd3, 5'd31);
        checkOutput("clear_write_rd", rdata[31:0], 32'd0);
        checkOutput("clear_rd_p1", rdata[63:32], 32'd0);
        countBusy(1'b0, n);
        checkOutput("clear_sweep_len", n + 1, 32'd31);
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'(a), 5'(a));
            checkOutput($sformatf("cleared_%0d", a), rdata[31:0], 32'd0);
        end

        // Reset in the middle of a sweep, with clear_req and a write on the same edge
        applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        for (int i = 1; i < 10; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0);
        end
        checkOutput("midsweep_busy", {31'b0, busy}, 32'd1);
        reset       = 1'b1;
        clear_req   = 1'b1;
        writeenable = 1'b1;
        writeto     = 5'd2;
        writedat    = 32'h22;
        tick();
        reset       = 1'b0;
        clear_req   = 1'b0;
        writeenable = 1'b0;
        countBusy(1'b0, n);
        checkOutput("restart_sweep_len", n, 32'd31);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd2, 5'd9);
        checkOutput("restart_rd2", rdata[31:0], 32'd0);
        checkOutput("restart_rd9", rdata[63:32], 32'd0);

        // Four read ports, eight entries
        reset4 = 1'b1;
        tick();
        reset4 = 1'b0;
        countBusy(1'b1, n);
        checkOutput("nrd4_sweep_len", n, 32'd7);
        exp4 = '{32'h11111111, 32'h22222222, 32'h55555555, 32'h66666666};
        writeenable4 = 1'b1;
        writeto4 = 3'd1; writedat4 = exp4[0]; tick();
        writeto4 = 3'd2; writedat4 = exp4[1]; tick();
        writeto4 = 3'd5; writedat4 = exp4[2]; tick();
        writeto4 = 3'd6; writedat4 = exp4[3]; tick();
        writeenable4 = 1'b0;
        raddr4 = {3'd6, 3'd5, 3'd2, 3'd1};
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("nrd4_port%0d", k), rdata4[k*32 +: 32], exp4[k]);
        end
        raddr4 = {3'd5, 3'd5, 3'd5, 3'd5};
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("nrd4_same%0d", k), rdata4[k*32 +: 32], 32'h55555555);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
